// File: rtl/crc_frame_ctrl.sv
// Packet framer around a CRC-16 engine: passes payload words through, then appends the CRC.
// Also enforces a maximum payload length and keeps packet and error counters.

module crc_ver (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_in,
   input  logic        crc_en,
   output logic [15:0] crc_out
);

   // x^16 + x^14 + x^12 + x^7 + x^3 + 1, processed MSB first, 16 bits per cycle
   localparam logic [15:0] Poly = 16'h5089;

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      for (int i = 15; i >= 0; i--) begin
         if (crc_d[15] ^ data_in[i]) begin
            crc_d = {crc_d[14:0], 1'b0} ^ Poly;
         end else begin
            crc_d = {crc_d[14:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q <= 16'hFFFF;
      end else if (crc_en) begin
         crc_q <= crc_d;
      end
   end

   assign crc_out = crc_q;

endmodule

module crc_frame_ctrl #(
   parameter int unsigned MAX_WORDS = 1024,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [15:0]      m_data,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   output logic             busy,
   output logic             err_overlen,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [15:0] LastIdx = 16'(MAX_WORDS - 1);

   typedef enum logic [1:0] {StSeed, StData, StCrc, StDrop} state_e;

   state_e           state_q, state_d;
   logic [15:0]      wcnt_q, wcnt_d;
   logic             clr_q;
   logic             err_q;
   logic [CNT_W-1:0] pkt_q, err_cnt_q;
   logic             trunc;
   logic             pkt_done;
   logic             crc_en;
   logic             eng_rst;
   logic [15:0]      crc_out;

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      s_ready  = 1'b0;
      m_valid  = 1'b0;
      m_last   = 1'b0;
      m_data   = '0;
      trunc    = 1'b0;
      pkt_done = 1'b0;
      case (state_q)
         StSeed: begin
            state_d = StData;
         end
         StData: begin
            m_data  = s_data;
            m_valid = s_valid;
            s_ready = m_ready;
            if (s_valid && m_ready) begin
               wcnt_d = wcnt_q + 16'd1;
               if (s_last) begin
                  state_d = StCrc;
               end else if (wcnt_q == LastIdx) begin
                  // Over-long packet: close it here, swallow the rest until s_last
                  trunc   = 1'b1;
                  state_d = StDrop;
               end
            end
         end
         StCrc: begin
            m_valid = 1'b1;
            m_last  = 1'b1;
            m_data  = crc_out;
            if (m_ready) begin
               pkt_done = 1'b1;
               wcnt_d   = '0;
               state_d  = StSeed;
            end
         end
         StDrop: begin
            s_ready = 1'b1;
            if (s_valid && s_last) begin
               state_d = StCrc;
            end
         end
         default: begin
            state_d = StSeed;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StSeed;
         wcnt_q    <= '0;
         clr_q     <= 1'b1;
         err_q     <= 1'b0;
         pkt_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         clr_q   <= (state_d == StSeed);
         err_q   <= trunc;
         if (pkt_done) begin
            pkt_q <= pkt_q + CNT_W'(1);
         end
         if (trunc && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
         end
      end
   end

   // Engine is held at its seed for the whole SEED cycle
   assign eng_rst = rst | clr_q;
   assign crc_en  = s_valid & s_ready & (state_q == StData);

   crc_ver u_crc (
      .clk     (clk),
      .rst     (eng_rst),
      .data_in (s_data),
      .crc_en  (crc_en),
      .crc_out (crc_out)
   );

   assign busy        = ((state_q == StData) && (wcnt_q != '0)) || (state_q == StCrc) ||
                        (state_q == StDrop);
   assign err_overlen = err_q;
   assign pkt_count   = pkt_q;
   assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Scoreboard bench for crc_frame_ctrl: stimulus pushes expected output words into a queue,
// a negedge monitor pops and compares every accepted output word.

module tb_crc_frame_ctrl;

   localparam int unsigned MAXW = 4;
   localparam int unsigned CW   = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic [15:0]   m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_ready = 1'b1;
   logic          busy;
   logic          err_overlen;
   logic [CW-1:0] pkt_count;
   logic [CW-1:0] err_count;

   always #5 clk = ~clk;

   crc_frame_ctrl #(
      .MAX_WORDS (MAXW),
      .CNT_W     (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_last      (m_last),
      .m_ready     (m_ready),
      .busy        (busy),
      .err_overlen (err_overlen),
      .pkt_count   (pkt_count),
      .err_count   (err_count)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] pw[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          ovl_seen = 0;
   int          exp_pkt = 0;
   int          exp_err = 0;
   bit          stall_en = 1'b0;
   bit          bubble_en = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: bound expired, got no progress, expected completion", name);
   endtask

   // Reference CRC in reflected form (right shift, reversed polynomial), bit-reversed at the end
   function automatic logic [15:0] ref_crc(input int n);
      logic [15:0] r = 16'hFFFF;
      logic [15:0] o;
      logic [15:0] d;
      for (int k = 0; k < n; k++) begin
         d = pw[k];
         for (int i = 15; i >= 0; i--) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h910A;
            else r = r >> 1;
         end
      end
      for (int i = 0; i < 16; i++) o[i] = r[15-i];
      return o;
   endfunction

   task automatic send_word(input logic [15:0] d, input logic l);
      int t  = 0;
      bit hs = 1'b0;
      s_data  = d;
      s_last  = l;
      s_valid = 1'b1;
      while (!hs) begin
         @(negedge clk);
         hs = s_ready;
         @(posedge clk);
         #1;
         t++;
         if (!hs && t > 200) begin
            fail_bound("send_word");
            s_valid = 1'b0;
            return;
         end
      end
   endtask

   task automatic send_pkt(input bit keep, input bit fixed, input logic [15:0] fixed_crc);
      int n  = pw.size();
      int np = (n > int'(MAXW)) ? int'(MAXW) : n;
      for (int i = 0; i < np; i++) exp_q.push_back({pw[i], 1'b0});
      exp_q.push_back({fixed ? fixed_crc : ref_crc(np), 1'b1});
      exp_pkt++;
      if (n > int'(MAXW)) exp_err++;
      for (int i = 0; i < n; i++) send_word(pw[i], (i == n - 1));
      if (!keep) begin
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() != 0) fail_bound("drain");
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_valid = 1'b0;
      s_last = 1'b0;
      exp_q.delete();
      exp_pkt = 0;
      exp_err = 0;
      ovl_seen = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Downstream ready: random stalls when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Monitor
   initial begin
      bit          hold = 1'b0;
      logic [15:0] hold_d = '0;
      logic        hold_l = 1'b0;
      bit          counting = 1'b0;
      bit          count_chk = 1'b0;
      int          bubble_cnt = 0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
            counting = 1'b0;
         end else begin
            if (err_overlen) ovl_seen++;
            if (hold) begin
               check("stall_valid", 16'(m_valid), 16'd1);
               check("stall_data", m_data, hold_d);
               check("stall_last", 16'(m_last), 16'(hold_l));
            end
            if (counting) begin
               if (s_valid && s_ready) begin
                  if (count_chk) check("seed_bubble", 16'(bubble_cnt), 16'd1);
                  counting = 1'b0;
               end else if (!s_ready) begin
                  bubble_cnt++;
               end
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_word: got %h, expected no word", m_data);
               end else begin
                  e = exp_q.pop_front();
                  check("m_data", m_data, e.d);
                  check("m_last", 16'(m_last), 16'(e.l));
               end
               if (m_last) begin
                  counting = 1'b1;
                  count_chk = bubble_en;
                  bubble_cnt = 0;
               end
            end
            hold   = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
         end
      end
   end

   initial begin
      // Reset values
      #3;
      check("rst_s_ready", 16'(s_ready), 16'd0);
      check("rst_m_valid", 16'(m_valid), 16'd0);
      check("rst_m_last", 16'(m_last), 16'd0);
      check("rst_m_data", m_data, 16'h0000);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_err_overlen", 16'(err_overlen), 16'd0);
      check("rst_pkt_count", pkt_count, 16'd0);
      check("rst_err_count", err_count, 16'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("seed_s_ready", 16'(s_ready), 16'd0);
      @(posedge clk);
      #1;

      // 1: single zero word
      pw = '{16'h0000};
      send_pkt(1'b0, 1'b1, 16'h916B);
      drain();
      check("t1_pkt_count", pkt_count, 16'd1);

      // 2: all-ones word, then all-ones followed by zero
      pw = '{16'hFFFF};
      send_pkt(1'b0, 1'b1, 16'h0000);
      pw = '{16'hFFFF, 16'h0000};
      send_pkt(1'b0, 1'b1, 16'h0000);
      drain();
      check("t2_pkt_count", pkt_count, 16'd3);

      // 3: back-to-back packets with s_valid held high
      bubble_en = 1'b1;
      pw = '{16'h1234, 16'hABCD};
      send_pkt(1'b1, 1'b0, 16'h0000);
      pw = '{16'h0000};
      send_pkt(1'b1, 1'b1, 16'h916B);
      pw = '{16'h0000};
      send_pkt(1'b0, 1'b1, 16'h916B);
      bubble_en = 1'b0;
      drain();
      check("t3_pkt_count", pkt_count, 16'(exp_pkt));

      // 4: random downstream stalls
      stall_en = 1'b1;
      for (int p = 0; p < 8; p++) begin
         pw.delete();
         for (int i = 0; i < int'($urandom_range(1, MAXW)); i++) pw.push_back(16'($urandom));
         send_pkt(1'b0, 1'b0, 16'h0000);
      end
      drain();
      stall_en = 1'b0;
      drain();
      check("t4_pkt_count", pkt_count, 16'(exp_pkt));
      check("t4_err_count", err_count, 16'd0);

      // 5: over-long packet, 6 words with MAX_WORDS=4
      do_reset();
      pw = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
      send_pkt(1'b0, 1'b0, 16'h0000);
      drain();
      check("t5_err_count", err_count, 16'(exp_err));
      check("t5_pkt_count", pkt_count, 16'd1);
      check("t5_overlen_pulses", 16'(ovl_seen), 16'd1);
      check("t5_busy_idle", 16'(busy), 16'd0);

      // 6: reset during the third word
      exp_q.push_back({16'h1111, 1'b0});
      exp_q.push_back({16'h2222, 1'b0});
      send_word(16'h1111, 1'b0);
      send_word(16'h2222, 1'b0);
      check("t6_busy_mid", 16'(busy), 16'd1);
      s_data  = 16'h3333;
      s_last  = 1'b0;
      s_valid = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      check("t6_rst_m_valid", 16'(m_valid), 16'd0);
      check("t6_rst_s_ready", 16'(s_ready), 16'd0);
      check("t6_rst_m_data", m_data, 16'h0000);
      check("t6_rst_busy", 16'(busy), 16'd0);
      check("t6_rst_pkt_count", pkt_count, 16'd0);
      do_reset();
      pw = '{16'h0000};
      send_pkt(1'b0, 1'b1, 16'h916B);
      drain();
      check("t6_pkt_count", pkt_count, 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
